// File: rtl/pe_psum_sequencer_pkg.sv
// Shared definitions for the PE psum sequencer: default widths and FSM state encoding.
package pe_psum_sequencer_pkg;

    localparam int LEN_W_DEF      = 4;
    localparam int CNT_W_DEF      = 4;
    localparam int PSUM_DEPTH_DEF = 4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_MAC   = 3'd2,
        S_WB    = 3'd3,
        S_DRAIN = 3'd4,
        S_DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/pe_psum_sequencer_step_counter.sv
// Up-counter with clear, increment and terminal compare against a latched limit.
// It returns to zero on the increment that hits the limit, so it never passes it.
module step_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] last,
    output logic         tc,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clr || (inc && tc)) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + W'(1);
        end
    end

    assign tc   = (cnt == last);
    assign zero = (cnt == '0);

endmodule

// File: rtl/pe_psum_sequencer.sv
// Sequences one PE pass: clear psum pad, MAC over each filter window, write back, drain.
//   state | meaning
//   IDLE  | waiting for start, cfg latched on accept
//   CLR   | clear psum scratch-pad pointers, reset tap/output counters
//   MAC   | pop ifmap/filter heads into the MAC while both FIFOs have data
//   WB    | write finished accumulator into the psum scratch pad
//   DRAIN | hand psums downstream until the scratch pad is empty
//   DONE  | one-cycle done (plus cfg_err / psum_clear when applicable)
module pe_psum_sequencer
    import pe_psum_sequencer_pkg::*;
#(
    parameter int LEN_W      = LEN_W_DEF,
    parameter int CNT_W      = CNT_W_DEF,
    parameter int PSUM_DEPTH = PSUM_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             abort,
    input  logic [LEN_W-1:0] cfg_filt_len,
    input  logic [CNT_W-1:0] cfg_num_out,
    input  logic             ifmap_empty,
    input  logic             filt_empty,
    input  logic             psum_full,
    input  logic             psum_empty,
    input  logic             out_ready,
    output logic             ifmap_ren,
    output logic             filt_ren,
    output logic             mac_en,
    output logic             acc_first,
    output logic             psum_wen,
    output logic             psum_ren,
    output logic             psum_clear,
    output logic             out_valid,
    output logic             busy,
    output logic             done,
    output logic             cfg_err
);

    state_t           state;
    logic [LEN_W-1:0] len_q;
    logic [CNT_W-1:0] num_q;
    logic             aborted_q;
    logic             err_q;

    logic k_tc, k_zero, o_tc, o_zero_unused;
    logic tap_fire, wb_fire;

    // Each FIFO flag passes through a single AND with a registered state decode.
    assign tap_fire = (state == S_MAC) & ~ifmap_empty & ~filt_empty;
    assign wb_fire  = (state == S_WB) & ~psum_full;

    assign ifmap_ren  = tap_fire;
    assign filt_ren   = tap_fire;
    assign mac_en     = tap_fire;
    assign acc_first  = tap_fire & k_zero;
    assign psum_wen   = wb_fire;
    assign out_valid  = (state == S_DRAIN) & ~psum_empty;
    assign psum_ren   = (state == S_DRAIN) & ~psum_empty & out_ready;
    assign psum_clear = (state == S_CLR) | ((state == S_DONE) & aborted_q);
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);
    assign cfg_err    = (state == S_DONE) & err_q;

    step_counter #(.W(LEN_W)) u_tap_cnt (
        .clk  (clk),
        .rstn (rstn),
        .clr  (state == S_CLR),
        .inc  (tap_fire),
        .last (len_q - LEN_W'(1)),
        .tc   (k_tc),
        .zero (k_zero)
    );

    step_counter #(.W(CNT_W)) u_out_cnt (
        .clk  (clk),
        .rstn (rstn),
        .clr  (state == S_CLR),
        .inc  (wb_fire),
        .last (num_q - CNT_W'(1)),
        .tc   (o_tc),
        .zero (o_zero_unused)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= S_IDLE;
            len_q     <= '0;
            num_q     <= '0;
            aborted_q <= 1'b0;
            err_q     <= 1'b0;
        end else if (abort && (state != S_IDLE)) begin
            state     <= S_DONE;
            aborted_q <= 1'b1;
            err_q     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    aborted_q <= 1'b0;
                    err_q     <= 1'b0;
                    if (start) begin
                        len_q <= cfg_filt_len;
                        num_q <= cfg_num_out;
                        // An oversized pass cannot fit the scratch pad; report it, do no work.
                        if (cfg_num_out > CNT_W'(PSUM_DEPTH)) begin
                            state <= S_DONE;
                            err_q <= 1'b1;
                        end else if ((cfg_filt_len == '0) || (cfg_num_out == '0)) begin
                            state <= S_DONE;
                        end else begin
                            state <= S_CLR;
                        end
                    end
                end
                S_CLR: state <= S_MAC;
                S_MAC: begin
                    if (tap_fire && k_tc) state <= S_WB;
                end
                S_WB: begin
                    if (wb_fire) state <= o_tc ? S_DRAIN : S_MAC;
                end
                S_DRAIN: begin
                    if (psum_empty) state <= S_DONE;
                end
                S_DONE: begin
                    state     <= S_IDLE;
                    aborted_q <= 1'b0;
                    err_q     <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_psum_sequencer.sv
// Directed and randomized passes checked against a tap/writeback/drain count model.
module tb_pe_psum_sequencer;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rstn, start, abort;
    logic [3:0] cfg_filt_len, cfg_num_out;
    logic       ifmap_empty, filt_empty, psum_full, psum_empty, out_ready;
    logic       ifmap_ren, filt_ren, mac_en, acc_first, psum_wen, psum_ren;
    logic       psum_clear, out_valid, busy, done, cfg_err;

    int tests = 0;
    int fails = 0;
    int pcnt  = 0;

    always #5 clk = ~clk;

    pe_psum_sequencer #(.LEN_W(4), .CNT_W(4), .PSUM_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .start        (start),
        .abort        (abort),
        .cfg_filt_len (cfg_filt_len),
        .cfg_num_out  (cfg_num_out),
        .ifmap_empty  (ifmap_empty),
        .filt_empty   (filt_empty),
        .psum_full    (psum_full),
        .psum_empty   (psum_empty),
        .out_ready    (out_ready),
        .ifmap_ren    (ifmap_ren),
        .filt_ren     (filt_ren),
        .mac_en       (mac_en),
        .acc_first    (acc_first),
        .psum_wen     (psum_wen),
        .psum_ren     (psum_ren),
        .psum_clear   (psum_clear),
        .out_valid    (out_valid),
        .busy         (busy),
        .done         (done),
        .cfg_err      (cfg_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {21'b0, ifmap_ren, filt_ren, mac_en, acc_first, psum_wen, psum_ren,
                psum_clear, out_valid, busy, done, cfg_err};
    endfunction

    // Scratch-pad occupancy as seen by the sequencer; flags change only at negedge drive.
    task automatic drive_psum();
        psum_empty = (pcnt == 0);
        psum_full  = (pcnt >= DEPTH);
    endtask

    task automatic upd_psum();
        if (psum_clear) pcnt = 0;
        if (psum_wen) pcnt++;
        if (psum_ren && pcnt > 0) pcnt--;
    endtask

    // mode 0: clean, 1: ifmap empty 2 cycles after first tap, 2: out_ready low 3 drain cycles, 3: random
    task automatic run_pass(input string nm, input int len, input int num, input int mode, input int abort_tap);
        int taps = 0, writes = 0, pops = 0, cyc = 0, done_cyc = -1, stalls = 0, rlow = 0;
        bit cleared = 0, wb_owed = 0, drain_end = 0, ab_next = 0, fin = 0, fire;
        @(negedge clk);
        start = 1'b1; abort = 1'b0;
        cfg_filt_len = 4'(len); cfg_num_out = 4'(num);
        ifmap_empty = 1'b0; filt_empty = 1'b0; out_ready = 1'b1;
        drive_psum();
        #1 chk({nm, " idle_busy"}, busy, 0);
        while (!fin && cyc < 500) begin
            @(negedge clk);
            start = (mode == 3) ? ($urandom_range(1) == 1) : 1'b0;
            abort = 1'b0; ifmap_empty = 1'b0; filt_empty = 1'b0; out_ready = 1'b1;
            if (mode == 3) begin
                ifmap_empty = ($urandom_range(3) == 0);
                filt_empty  = ($urandom_range(3) == 0);
                out_ready   = ($urandom_range(2) != 0);
            end
            if (mode == 1 && cleared && !wb_owed && taps == 1 && stalls < 2) begin
                ifmap_empty = 1'b1; stalls++;
            end
            if (mode == 2 && writes == num && rlow < 3) begin
                out_ready = 1'b0; rlow++;
            end
            fire = cleared && writes < num && !wb_owed && !ifmap_empty && !filt_empty;
            if (abort_tap >= 0 && fire && taps == abort_tap) abort = 1'b1;
            drive_psum();
            #1;
            if (ab_next) begin
                chk({nm, " abort_done"}, done, 1);
                chk({nm, " abort_clear"}, psum_clear, 1);
                chk({nm, " abort_err"}, cfg_err, 0);
                chk({nm, " abort_ren"}, ifmap_ren, 0);
                fin = 1; done_cyc = cyc;
            end else if (!cleared) begin
                chk({nm, " clr"}, psum_clear, 1);
                chk({nm, " clr_ren"}, ifmap_ren, 0);
                chk({nm, " clr_busy"}, busy, 1);
                cleared = 1;
            end else if (writes < num && wb_owed) begin
                chk({nm, " wen"}, psum_wen, 1);
                chk({nm, " wb_ren"}, ifmap_ren, 0);
                writes++; wb_owed = 0;
            end else if (writes < num) begin
                chk({nm, " ifmap_ren"}, ifmap_ren, fire);
                chk({nm, " filt_ren"}, filt_ren, fire);
                chk({nm, " mac_en"}, mac_en, fire);
                chk({nm, " acc_first"}, acc_first, fire && (taps % len == 0));
                chk({nm, " mac_wen"}, psum_wen, 0);
                if (fire) begin
                    taps++;
                    if (taps % len == 0) wb_owed = 1;
                end
            end else if (!drain_end) begin
                chk({nm, " out_valid"}, out_valid, pcnt > 0);
                chk({nm, " psum_ren"}, psum_ren, pcnt > 0 && out_ready);
                chk({nm, " drain_done"}, done, 0);
                if (pcnt > 0 && out_ready) pops++;
                else if (pcnt == 0) drain_end = 1;
            end else begin
                chk({nm, " done"}, done, 1);
                chk({nm, " done_err"}, cfg_err, 0);
                chk({nm, " done_clear"}, psum_clear, 0);
                fin = 1; done_cyc = cyc;
            end
            if (abort) ab_next = 1;
            upd_psum();
            cyc++;
        end
        chk({nm, " finished"}, fin, 1);
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        drive_psum();
        #1;
        chk({nm, " idle_after"}, busy, 0);
        chk({nm, " done_after"}, done, 0);
        if (abort_tap < 0) begin
            chk({nm, " taps"}, taps, len * num);
            chk({nm, " pops"}, pops, num);
            chk({nm, " pad_left"}, pcnt, 0);
        end
        if (mode == 0 && abort_tap < 0) chk({nm, " latency"}, done_cyc, 1 + num * (len + 1) + num + 1);
        if (mode == 1) chk({nm, " latency"}, done_cyc, 1 + num * (len + 1) + num + 1 + 2);
        if (mode == 2) chk({nm, " latency"}, done_cyc, 1 + num * (len + 1) + num + 1 + 3);
    endtask

    task automatic null_start(input string nm, input int len, input int num, input bit exp_err);
        @(negedge clk);
        start = 1'b1; cfg_filt_len = 4'(len); cfg_num_out = 4'(num);
        @(negedge clk);
        start = 1'b0;
        #1;
        chk({nm, " done"}, done, 1);
        chk({nm, " cfg_err"}, cfg_err, exp_err);
        chk({nm, " clear"}, psum_clear, 0);
        chk({nm, " ren"}, ifmap_ren, 0);
        chk({nm, " busy"}, busy, 1);
        @(negedge clk);
        #1 chk({nm, " idle"}, busy, 0);
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; abort = 1'b0;
        cfg_filt_len = '0; cfg_num_out = '0;
        ifmap_empty = 1'b1; filt_empty = 1'b1; out_ready = 1'b0;
        drive_psum();
        @(negedge clk);
        @(negedge clk);
        #1 chk("reset outs", all_outs(), 0);
        rstn = 1'b1;

        run_pass("basic", 3, 2, 0, -1);
        run_pass("stall", 3, 2, 1, -1);
        run_pass("ready_low", 3, 2, 2, -1);
        run_pass("abort", 3, 2, 0, 1);
        run_pass("depth", 2, DEPTH, 0, -1);
        run_pass("len1", 1, 1, 0, -1);
        run_pass("len15", 15, 1, 0, -1);

        null_start("cfg_big", 3, 5, 1'b1);
        null_start("len0", 0, 2, 1'b0);
        null_start("num0", 3, 0, 1'b0);

        // abort while idle must not start anything
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #1;
        chk("idle_abort busy", busy, 0);
        chk("idle_abort done", done, 0);

        // reset in the middle of a window, then start right after release
        @(negedge clk);
        start = 1'b1; cfg_filt_len = 4'd4; cfg_num_out = 4'd2;
        ifmap_empty = 1'b0; filt_empty = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #1 chk("pre_reset mac_en", mac_en, 1);
        rstn = 1'b0;
        @(negedge clk);
        #1 chk("mid_reset outs", all_outs(), 0);
        pcnt = 0; drive_psum();
        rstn = 1'b1; start = 1'b1; cfg_filt_len = 4'd2; cfg_num_out = 4'd1;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("post_reset clear", psum_clear, 1);
        chk("post_reset busy", busy, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #1;
        chk("post_reset abort_done", done, 1);
        chk("post_reset abort_clear", psum_clear, 1);
        pcnt = 0; drive_psum();
        @(negedge clk);
        #1 chk("post_reset idle", busy, 0);

        for (int i = 0; i < 6; i++) begin
            run_pass($sformatf("rand%0d", i), $urandom_range(7, 1), $urandom_range(DEPTH, 1), 3, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
